// File: rtl/text_write_ctrl.sv
// Write-side sequencer for the 80x30 text RAM.
// Received SPI bytes are turned into cell writes at a hardware cursor.
// The sequencer also handles CR/LF/BS, ESC row/col positioning and a
// full-screen clear fill that writes one cell per clock.
module text_write_ctrl #(
  parameter int          COLS      = 80,
  parameter int          ROWS      = 30,
  parameter int          ADDR_W    = 12,
  parameter logic [7:0]  FILL_CHAR = 8'h20
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        rx_byte,
  input  logic              rx_valid,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [7:0]        wr_data,
  output logic              busy,
  output logic              drop,
  output logic [6:0]        cur_col,
  output logic [4:0]        cur_row
);

  typedef enum logic [1:0] {IDLE, ESC_ROW, ESC_COL, CLEAR} state_t;

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(COLS * ROWS - 1);
  localparam logic [6:0]        LAST_COL  = 7'(COLS - 1);
  localparam logic [4:0]        LAST_ROW  = 5'(ROWS - 1);

  localparam logic [7:0] CH_BS  = 8'h08;
  localparam logic [7:0] CH_LF  = 8'h0A;
  localparam logic [7:0] CH_FF  = 8'h0C;
  localparam logic [7:0] CH_CR  = 8'h0D;
  localparam logic [7:0] CH_ESC = 8'h1B;
  localparam logic [7:0] CH_DEL = 8'h7F;

  state_t            state;
  logic [4:0]        row_pend;
  logic [ADDR_W-1:0] cur_addr;
  logic              printable;

  // Limit an ESC row byte to the last screen row.
  function automatic logic [4:0] clamp_row(input logic [7:0] b);
    if (b > 8'(ROWS - 1)) return LAST_ROW;
    else                  return b[4:0];
  endfunction

  // Limit an ESC column byte to the last screen column.
  function automatic logic [6:0] clamp_col(input logic [7:0] b);
    if (b > 8'(COLS - 1)) return LAST_COL;
    else                  return b[6:0];
  endfunction

  // Linear cell address of the cursor, and whether the byte is a glyph.
  assign cur_addr  = ADDR_W'(cur_row) * ADDR_W'(COLS) + ADDR_W'(cur_col);
  assign printable = (rx_byte >= 8'h20) && (rx_byte != CH_DEL);

  // Sequencer: byte decode, cursor movement, ESC positioning and clear fill.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      row_pend <= '0;
      wr_en    <= 1'b0;
      wr_addr  <= '0;
      wr_data  <= '0;
      busy     <= 1'b0;
      drop     <= 1'b0;
      cur_col  <= '0;
      cur_row  <= '0;
    end else begin
      wr_en <= 1'b0;
      drop  <= 1'b0;
      case (state)
        IDLE: begin
          if (rx_valid) begin
            if (printable) begin
              wr_en   <= 1'b1;
              wr_addr <= cur_addr;
              wr_data <= rx_byte;
              if (cur_col == LAST_COL) begin
                cur_col <= '0;
                cur_row <= (cur_row == LAST_ROW) ? 5'd0 : cur_row + 5'd1;
              end else begin
                cur_col <= cur_col + 7'd1;
              end
            end else begin
              case (rx_byte)
                CH_CR:  cur_col <= '0;
                CH_LF:  cur_row <= (cur_row == LAST_ROW) ? 5'd0 : cur_row + 5'd1;
                CH_BS:  if (cur_col != 7'd0) cur_col <= cur_col - 7'd1;
                CH_ESC: state <= ESC_ROW;
                CH_FF: begin
                  // The first fill write goes out on the same edge busy rises.
                  state   <= CLEAR;
                  busy    <= 1'b1;
                  wr_en   <= 1'b1;
                  wr_addr <= '0;
                  wr_data <= FILL_CHAR;
                end
                default: ;
              endcase
            end
          end
        end
        ESC_ROW: begin
          if (rx_valid) begin
            row_pend <= clamp_row(rx_byte);
            state    <= ESC_COL;
          end
        end
        ESC_COL: begin
          if (rx_valid) begin
            cur_row <= row_pend;
            cur_col <= clamp_col(rx_byte);
            state   <= IDLE;
          end
        end
        CLEAR: begin
          if (rx_valid) drop <= 1'b1;
          if (wr_addr == LAST_ADDR) begin
            busy    <= 1'b0;
            cur_col <= '0;
            cur_row <= '0;
            state   <= IDLE;
          end else begin
            wr_en   <= 1'b1;
            wr_addr <= wr_addr + ADDR_W'(1);
            wr_data <= FILL_CHAR;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_text_write_ctrl.sv
// Directed bench for text_write_ctrl.
module tb_text_write_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  rx_byte = 8'h00;
  logic        rx_valid = 1'b0;
  logic        wr_en;
  logic [11:0] wr_addr;
  logic [7:0]  wr_data;
  logic        busy;
  logic        drop;
  logic [6:0]  cur_col;
  logic [4:0]  cur_row;

  int n_checks = 0;
  int n_fail   = 0;

  text_write_ctrl dut (
    .clk      (clk),
    .rst      (rst),
    .rx_byte  (rx_byte),
    .rx_valid (rx_valid),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .busy     (busy),
    .drop     (drop),
    .cur_col  (cur_col),
    .cur_row  (cur_row)
  );

  always #10 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Present one byte for one clock; returns at the falling edge after the
  // sampling edge, where the registered response is visible.
  task automatic send(input logic [7:0] b);
    @(negedge clk);
    rx_byte  = b;
    rx_valid = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic check_write(input string tag, input logic [11:0] a, input logic [7:0] d);
    check({tag, "_wr_en"},   32'(wr_en),   32'd1);
    check({tag, "_wr_addr"}, 32'(wr_addr), 32'(a));
    check({tag, "_wr_data"}, 32'(wr_data), 32'(d));
  endtask

  task automatic check_cursor(input string tag, input int col, input int row);
    check({tag, "_col"}, 32'(cur_col), 32'(col));
    check({tag, "_row"}, 32'(cur_row), 32'(row));
  endtask

  initial begin
    bit bad;
    int drops;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_wr_en", 32'(wr_en), 0);
    check("rst_wr_addr", 32'(wr_addr), 0);
    check("rst_wr_data", 32'(wr_data), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_drop", 32'(drop), 0);
    check_cursor("rst", 0, 0);
    rst = 1'b0;

    // 'A' at origin
    send(8'h41);
    check_write("A", 12'd0, 8'h41);
    check_cursor("A", 1, 0);
    @(negedge clk);
    check("A_wr_en_pulse", 32'(wr_en), 0);

    // ESC 29 79 then 'Z' at last cell, cursor wraps
    send(8'h1B);
    check("esc_no_wr", 32'(wr_en), 0);
    send(8'd29);
    check_cursor("esc_row_pending", 1, 0);
    send(8'd79);
    check("esc_col_no_wr", 32'(wr_en), 0);
    check_cursor("esc_pos", 79, 29);
    send(8'h5A);
    check_write("Z", 12'd2399, 8'h5A);
    check_cursor("Z_wrap", 0, 0);

    // Clamped ESC, CR, LF wrap
    send(8'h1B); send(8'd200); send(8'd200);
    check_cursor("clamp", 79, 29);
    send(8'h0D);
    check("cr_no_wr", 32'(wr_en), 0);
    check_cursor("cr", 0, 29);
    send(8'h0A);
    check("lf_no_wr", 32'(wr_en), 0);
    check_cursor("lf_wrap", 0, 0);

    // End-of-row advance
    send(8'h1B); send(8'd0); send(8'd79);
    send(8'h78);
    check_write("eol", 12'd79, 8'h78);
    check_cursor("eol", 0, 1);

    // BS at col 0, then write, BS, ignored codes, high byte
    send(8'h08);
    check("bs0_no_wr", 32'(wr_en), 0);
    check_cursor("bs0", 0, 1);
    send(8'h71);
    check_write("q", 12'd80, 8'h71);
    check_cursor("q", 1, 1);
    send(8'h08);
    check("bs_no_wr", 32'(wr_en), 0);
    check_cursor("bs", 0, 1);
    send(8'h07);
    check("bel_no_wr", 32'(wr_en), 0);
    check_cursor("bel", 0, 1);
    send(8'h7F);
    check("del_no_wr", 32'(wr_en), 0);
    check_cursor("del", 0, 1);
    send(8'h80);
    check_write("hi", 12'd80, 8'h80);
    check_cursor("hi", 1, 1);

    // Full clear with a byte dropped mid-fill
    send(8'h0C);
    bad = 1'b0;
    drops = 0;
    for (int i = 0; i < 2400; i++) begin
      if (wr_en !== 1'b1 || wr_addr !== 12'(i) || wr_data !== 8'h20 || busy !== 1'b1)
        bad = 1'b1;
      if (drop === 1'b1) drops++;
      if (i == 500) begin
        rx_byte  = 8'h42;
        rx_valid = 1'b1;
      end
      @(negedge clk);
      rx_valid = 1'b0;
      if (i == 500) check("drop_pulse", 32'(drop), 1);
    end
    check("fill_sequence", 32'(bad), 0);
    check("drop_count", 32'(drops), 1);
    check("fill_done_busy", 32'(busy), 0);
    check("fill_done_wr_en", 32'(wr_en), 0);
    check_cursor("fill_done", 0, 0);

    // IDLE resumes after clear
    send(8'h44);
    check_write("after_clear", 12'd0, 8'h44);
    check_cursor("after_clear", 1, 0);

    // Reset during fill
    send(8'h0C);
    repeat (1000) @(negedge clk);
    check("fill_at_1000", 32'(wr_addr), 1000);
    rst = 1'b1;
    #1;
    check("abort_wr_en", 32'(wr_en), 0);
    check("abort_busy", 32'(busy), 0);
    check("abort_addr", 32'(wr_addr), 0);
    check_cursor("abort", 0, 0);
    @(negedge clk);
    rst = 1'b0;
    send(8'h43);
    check_write("C_after_abort", 12'd0, 8'h43);
    check_cursor("C_after_abort", 1, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
